// File: rtl/avg_sample_collector_if.sv
// Bus bundle for avg_sample_collector: capture side, read side and status.
// master = the environment (producer/consumer), slave = the collector.
interface avg_sample_collector_if #(
  parameter int DEPTH = 16,
  parameter int OVF_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                    enable;
  logic signed [15:0]      sample_in;
  logic                    sample_pulse;
  logic                    clear;
  logic                    rd_ready;
  logic                    rd_valid;
  logic signed [15:0]      rd_data;
  logic [LVL_W-1:0]        level;
  logic                    full;
  logic                    empty;
  logic [OVF_W-1:0]        overflow_cnt;
  logic signed [15:0]      min_val;
  logic signed [15:0]      max_val;
  logic                    stats_valid;

  modport master (
    output enable, sample_in, sample_pulse, clear, rd_ready,
    input  rd_valid, rd_data, level, full, empty, overflow_cnt,
           min_val, max_val, stats_valid
  );

  modport slave (
    input  enable, sample_in, sample_pulse, clear, rd_ready,
    output rd_valid, rd_data, level, full, empty, overflow_cnt,
           min_val, max_val, stats_valid
  );
endinterface

// File: rtl/avg_sample_collector.sv
// avg_sample_collector: show-ahead FIFO that captures moving-average output
// samples, counts samples dropped while full, and optionally tracks the
// running min/max of accepted samples.
// Optional feature macro: AVG_COLLECT_STATS_EN (min/max statistics logic).
// DEPTH must be a power of two in 4..64 so the pointers wrap for free.
module avg_sample_collector #(
  parameter int DEPTH = 16,
  parameter int OVF_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  avg_sample_collector_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;

  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign empty_s = (level_q == LVL_W'(0));
  assign full_s  = (level_q == LVL_W'(DEPTH));

  // Handshake decode; clear swallows any coincident traffic.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (bus.clear) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s  = !empty_s && bus.rd_ready;
      push_s = bus.enable && bus.sample_pulse && (!full_s || pop_s);
      drop_s = bus.enable && bus.sample_pulse && full_s && !pop_s;
    end
  end

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      level_d  = LVL_W'(0);
      ovf_d    = OVF_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (drop_s && (ovf_q != {OVF_W{1'b1}})) begin
        ovf_d = ovf_q + OVF_W'(1);
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LVL_W'(0);
      ovf_q    <= OVF_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= bus.sample_in;
    end
  end

  assign bus.rd_valid     = !empty_s;
  assign bus.rd_data      = empty_s ? 16'sd0 : mem_q[rd_ptr_q];
  assign bus.level        = level_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.overflow_cnt = ovf_q;

`ifdef AVG_COLLECT_STATS_EN
  logic signed [15:0] min_q, min_d;
  logic signed [15:0] max_q, max_d;
  logic               stats_valid_q, stats_valid_d;

  // Running min/max over accepted pushes; first push loads both.
  always_comb begin
    min_d         = min_q;
    max_d         = max_q;
    stats_valid_d = stats_valid_q;
    if (bus.clear) begin
      min_d         = 16'sd0;
      max_d         = 16'sd0;
      stats_valid_d = 1'b0;
    end else if (push_s) begin
      stats_valid_d = 1'b1;
      if (!stats_valid_q) begin
        min_d = bus.sample_in;
        max_d = bus.sample_in;
      end else begin
        min_d = (bus.sample_in < min_q) ? bus.sample_in : min_q;
        max_d = (bus.sample_in > max_q) ? bus.sample_in : max_q;
      end
    end else begin
      stats_valid_d = stats_valid_q;
    end
  end

  // Statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q         <= 16'sd0;
      max_q         <= 16'sd0;
      stats_valid_q <= 1'b0;
    end else begin
      min_q         <= min_d;
      max_q         <= max_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign bus.min_val     = min_q;
  assign bus.max_val     = max_q;
  assign bus.stats_valid = stats_valid_q;
`else
  assign bus.min_val     = 16'sd0;
  assign bus.max_val     = 16'sd0;
  assign bus.stats_valid = 1'b0;
`endif
endmodule

// File: tb/tb_avg_sample_collector.sv
// Directed + randomized bench for avg_sample_collector against a queue model.
module tb_avg_sample_collector;
  localparam int DEPTH = 16;
  localparam int OVF_W = 8;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avg_sample_collector_if #(.DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

  avg_sample_collector #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // reference model state
  int q[$];
  int m_ovf;
  bit m_sv;
  int m_min;
  int m_max;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit en, input bit pulse, input int smp,
                       input bit rdy, input bit clr);
    bus.enable       = en;
    bus.sample_pulse = pulse;
    bus.sample_in    = 16'(smp);
    bus.rd_ready     = rdy;
    bus.clear        = clr;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic cycle();
    bit pop, push, drop, r, c;
    int smp;
    pop  = (q.size() > 0) && bus.rd_ready;
    push = bus.enable && bus.sample_pulse && ((q.size() < DEPTH) || pop);
    drop = bus.enable && bus.sample_pulse && !push;
    smp  = int'(bus.sample_in);
    r    = rst;
    c    = bus.clear;
    @(posedge clk);
    #1;
    if (r || c) begin
      q.delete();
      m_ovf = 0;
      m_sv  = 1'b0;
      m_min = 0;
      m_max = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(smp);
        if (!m_sv) begin
          m_min = smp;
          m_max = smp;
          m_sv  = 1'b1;
        end else begin
          if (smp < m_min) m_min = smp;
          if (smp > m_max) m_max = smp;
        end
      end
      if (drop && m_ovf < OVF_MAX) m_ovf++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, bus.level, q.size());
    check({tag, ".empty"}, bus.empty, (q.size() == 0) ? 1 : 0);
    check({tag, ".full"}, bus.full, (q.size() == DEPTH) ? 1 : 0);
    check({tag, ".rd_valid"}, bus.rd_valid, (q.size() > 0) ? 1 : 0);
    check({tag, ".rd_data"}, bus.rd_data, (q.size() > 0) ? q[0] : 0);
    check({tag, ".ovf"}, bus.overflow_cnt, m_ovf);
`ifdef AVG_COLLECT_STATS_EN
    check({tag, ".min"}, bus.min_val, m_min);
    check({tag, ".max"}, bus.max_val, m_max);
    check({tag, ".sv"}, bus.stats_valid, m_sv ? 1 : 0);
`else
    check({tag, ".min"}, bus.min_val, 0);
    check({tag, ".max"}, bus.max_val, 0);
    check({tag, ".sv"}, bus.stats_valid, 0);
`endif
  endtask

  task automatic push_one(input int v, input bit rdy);
    drive(1'b1, 1'b1, v, rdy, 1'b0);
    cycle();
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  int stored[DEPTH];
  int exp38[3];
  int last;

  initial begin
    q.delete();
    m_ovf = 0; m_sv = 1'b0; m_min = 0; m_max = 0;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1234, 1'b1, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_all("reset");
    check("reset.rd_data0", bus.rd_data, 0);

    // ordered readback with level walk-down
    exp38[0] = 3; exp38[1] = -5; exp38[2] = 7;
    for (int i = 0; i < 3; i++) push_one(exp38[i], 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("r38.level3", bus.level, 3);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("r38.data", bus.rd_data, exp38[i]);
      cycle();
      check("r38.level", bus.level, 2 - i);
    end
    check("r38.empty", bus.empty, 1);

    // overflow while full, stored entries untouched
    for (int i = 0; i < DEPTH; i++) begin
      stored[i] = int'($urandom_range(0, 65535)) - 32768;
      push_one(stored[i], 1'b0);
    end
    for (int i = 0; i < 3; i++) push_one(16'h1111, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("r39.full", bus.full, 1);
    check("r39.ovf", bus.overflow_cnt, 3);
    check_all("r39");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("r39.readback", bus.rd_data, stored[i]);
      cycle();
    end
    check_all("r39.drained");
    do_clear();
    check_all("clear1");

    // simultaneous push+pop while full
    for (int i = 0; i < DEPTH; i++) push_one(i + 1, 1'b0);
    push_one(32767, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("r40.level", bus.level, DEPTH);
    check("r40.ovf", bus.overflow_cnt, 0);
    check_all("r40");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      last = int'(bus.rd_data);
      cycle();
    end
    check("r40.last", last, 32767);
    check_all("r40.drained");

    // clear with coincident pulse at level 5
    for (int i = 0; i < 5; i++) push_one(100 + i, 1'b0);
    drive(1'b1, 1'b1, 555, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("r41.level", bus.level, 0);
    check("r41.rd_valid", bus.rd_valid, 0);
    check("r41.ovf", bus.overflow_cnt, 0);
    check_all("r41");

    // saturation of the drop counter
    for (int i = 0; i < DEPTH; i++) push_one(-i, 1'b0);
    for (int i = 0; i < 300; i++) push_one(9, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("r42.ovf", bus.overflow_cnt, 255);
    check_all("r42");
    do_clear();
    check("clear2.ovf", bus.overflow_cnt, 0);

    // extreme values for statistics
    push_one(-32768, 1'b0);
    push_one(100, 1'b0);
    push_one(32767, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cycle();
`ifdef AVG_COLLECT_STATS_EN
    check("r43.min", bus.min_val, -32768);
    check("r43.max", bus.max_val, 32767);
    check("r43.sv", bus.stats_valid, 1);
`else
    check("r43.min", bus.min_val, 0);
    check("r43.max", bus.max_val, 0);
    check("r43.sv", bus.stats_valid, 0);
`endif
    check_all("r43");

    // enable low: pulse ignored
    drive(1'b0, 1'b1, 77, 1'b0, 1'b0);
    cycle();
    check("en0.level", bus.level, 3);
    check_all("en0");

    // mid-stream reset discards contents
    rst = 1'b1;
    push_one(42, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("rst_mid.level", bus.level, 0);
    check_all("rst_mid");

    // randomized traffic with phases biased toward filling or draining
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = (i / 100) % 3;
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) != 0,
            $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 65535)),
            (bias == 0) ? ($urandom_range(0, 3) == 0) :
            (bias == 1) ? ($urandom_range(0, 3) != 0) :
                          ($urandom_range(0, 1) == 0),
            $urandom_range(0, 99) == 0);
      cycle();
      check_all("rand");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
